// File: rtl/unibus_pkg.sv
// Shared definitions for the Unibus CPU-side arbiter: FSM state encoding,
// BR level constants, grant vector layout and default timeout values.
package unibus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SACKED,
        ST_MASTER,
        ST_VECTOR
    } arb_state_t;

    localparam logic [2:0] BR4_LVL = 3'd4;
    localparam logic [2:0] BR5_LVL = 3'd5;
    localparam logic [2:0] BR6_LVL = 3'd6;
    localparam logic [2:0] BR7_LVL = 3'd7;

    // Grant vector layout: bits 3:0 = BG7..BG4 (bit n-4 for level n), bit 4 = NPG
    localparam int unsigned GNT_W   = 5;
    localparam int unsigned NPR_BIT = 4;

    localparam int unsigned CNT_W            = 9;
    localparam int unsigned SACK_TIMEOUT_DEF = 'o400;
    localparam int unsigned BBSY_TIMEOUT_DEF = 'o400;

endpackage

// File: rtl/unibus_arb_if.sv
// Unibus arbitration/interrupt wiring between the CPU arbiter (master
// modport) and the bus devices (slave modport).
interface unibus_arb_if;

    logic [7:4] bus_br;
    logic       bus_npr;
    logic       bus_sack;
    logic       bus_bbsy;
    logic       bus_intr;
    logic [7:0] bus_d;
    logic [7:4] bus_bg_out;
    logic       bus_npg_out;
    logic       bus_ssyn_out;

    modport master (
        input  bus_br,
        input  bus_npr,
        input  bus_sack,
        input  bus_bbsy,
        input  bus_intr,
        input  bus_d,
        output bus_bg_out,
        output bus_npg_out,
        output bus_ssyn_out
    );

    modport slave (
        output bus_br,
        output bus_npr,
        output bus_sack,
        output bus_bbsy,
        output bus_intr,
        output bus_d,
        input  bus_bg_out,
        input  bus_npg_out,
        input  bus_ssyn_out
    );

endinterface

// File: rtl/unibus_prio_enc.sv
// Combinational grant selector: NPR (when UNIBUS_ARB_NPR_EN is defined) beats
// every BR level; otherwise the highest BR level above the CPU priority wins.
// Output is a one-hot grant vector plus a valid bit.
module unibus_prio_enc
    import unibus_pkg::*;
(
    input  logic [7:4]       br,
    input  logic [2:0]       prio,
    input  logic             br_en,
    input  logic             npr,
    input  logic             npr_en,
    output logic [GNT_W-1:0] gnt,
    output logic             valid
);

    logic       npr_win;
    logic       found;
    logic [2:0] lvl;

`ifdef UNIBUS_ARB_NPR_EN
    assign npr_win = npr & npr_en;
`else
    logic unused_npr;
    assign npr_win    = 1'b0;
    assign unused_npr = &{1'b0, npr, npr_en};
`endif

    // Pick NPR first, else scan BR7 down to BR4 for the first level above prio
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        lvl   = '0;
        if (npr_win) begin
            gnt[NPR_BIT] = 1'b1;
        end else if (br_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                lvl = BR7_LVL - 3'(i);
                if (!found && br[lvl] && (lvl > prio)) begin
                    gnt[2'(lvl - BR4_LVL)] = 1'b1;
                    found                  = 1'b1;
                end
            end
        end
    end

    assign valid = |gnt;

endmodule

// File: rtl/unibus_arb.sv
// CPU-side Unibus arbiter: grants BR7..BR4 / NPR one at a time, follows the
// SACK/BBSY hand-over, latches interrupt vectors and answers INTR with SSYN.
// Optional feature macro: UNIBUS_ARB_NPR_EN (NPR arbitration).
module unibus_arb
    import unibus_pkg::*;
#(
    parameter int unsigned SACK_TIMEOUT = SACK_TIMEOUT_DEF,
    parameter int unsigned BBSY_TIMEOUT = BBSY_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    unibus_arb_if.master bus,
    input  logic [2:0]   cpu_prio,
    input  logic         cpu_inst_done,
    input  logic         cpu_bus_free,
    output logic         cpu_hold,
    output logic         intr_req,
    output logic [7:2]   intr_vec,
    input  logic         intr_ack,
    output logic         arb_timeout
);

    localparam logic [CNT_W-1:0] SACK_LIM = CNT_W'(SACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BBSY_LIM = CNT_W'(BBSY_TIMEOUT - 1);

    // Sampled inputs: the FSM acts on the values captured one edge earlier
    logic [7:4]       s_br;
    logic             s_npr;
    logic             s_free;
    logic             s_sack;
    logic             s_bbsy;
    logic             s_intr;
    logic [7:2]       s_vec;
    logic [2:0]       s_prio;
    logic             s_done;
    logic             s_ack;

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [GNT_W-1:0] owner_q, owner_d;
    logic [GNT_W-1:0] gnt_q, gnt_d;
    logic             ssyn_q, ssyn_d;
    logic             hold_q, hold_d;
    logic             req_q, req_d;
    logic [7:2]       vec_q, vec_d;
    logic             tmo_q, tmo_d;

    logic [GNT_W-1:0] enc_gnt;
    logic             enc_valid;
    logic [GNT_W-1:0] req_lines;
    logic             unused_in;

    // Capture bus and CPU inputs every cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            s_br   <= '0;
            s_sack <= 1'b0;
            s_bbsy <= 1'b0;
            s_intr <= 1'b0;
            s_vec  <= '0;
            s_prio <= '0;
            s_done <= 1'b0;
            s_ack  <= 1'b0;
        end else begin
            s_br   <= bus.bus_br;
            s_sack <= bus.bus_sack;
            s_bbsy <= bus.bus_bbsy;
            s_intr <= bus.bus_intr;
            s_vec  <= bus.bus_d[7:2];
            s_prio <= cpu_prio;
            s_done <= cpu_inst_done;
            s_ack  <= intr_ack;
        end
    end

`ifdef UNIBUS_ARB_NPR_EN
    // Capture the NPR request and its arbitration point
    always_ff @(posedge clk) begin
        if (!reset) begin
            s_npr  <= 1'b0;
            s_free <= 1'b0;
        end else begin
            s_npr  <= bus.bus_npr;
            s_free <= cpu_bus_free;
        end
    end
    assign bus.bus_npg_out = gnt_q[NPR_BIT];
    assign unused_in       = &{1'b0, bus.bus_d[1:0]};
`else
    assign s_npr           = 1'b0;
    assign s_free          = 1'b0;
    assign bus.bus_npg_out = 1'b0;
    assign unused_in       = &{1'b0, bus.bus_d[1:0], bus.bus_npr, cpu_bus_free, gnt_q[NPR_BIT]};
`endif

    unibus_prio_enc u_prio_enc (
        .br     (s_br),
        .prio   (s_prio),
        .br_en  (s_done & ~req_q),
        .npr    (s_npr),
        .npr_en (s_free),
        .gnt    (enc_gnt),
        .valid  (enc_valid)
    );

    assign req_lines = {s_npr, s_br};

    // Next-state and next-output decode; outputs are registered from *_d
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = '0;
        ssyn_d  = 1'b0;
        req_d   = req_q;
        vec_d   = vec_q;
        tmo_d   = 1'b0;

        // A vector latched this cycle overrides the ack below
        if (s_ack) begin
            req_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d = ST_GRANT;
                    owner_d = enc_gnt;
                    gnt_d   = enc_gnt;
                end
            end
            ST_GRANT: begin
                if (s_sack) begin
                    state_d = ST_SACKED;
                end else if ((owner_q & req_lines) == '0) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == SACK_LIM) begin
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    gnt_d = owner_q;
                end
            end
            ST_SACKED: begin
                if (s_bbsy) begin
                    state_d = ST_MASTER;
                end else if (!s_sack) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == BBSY_LIM) begin
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
                end
            end
            ST_MASTER: begin
                if (s_intr && !owner_q[NPR_BIT]) begin
                    state_d = ST_VECTOR;
                    vec_d   = s_vec;
                    ssyn_d  = 1'b1;
                end else if (!s_bbsy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_VECTOR: begin
                if (s_intr) begin
                    ssyn_d = 1'b1;
                end else begin
                    req_d   = 1'b1;
                    state_d = s_bbsy ? ST_MASTER : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hold_d = (state_d != ST_IDLE);
    end

    // State, output and timeout-counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            gnt_q   <= '0;
            ssyn_q  <= 1'b0;
            hold_q  <= 1'b0;
            req_q   <= 1'b0;
            vec_q   <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ssyn_q  <= ssyn_d;
            hold_q  <= hold_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            tmo_q   <= tmo_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.bus_bg_out   = gnt_q[3:0];
    assign bus.bus_ssyn_out = ssyn_q;
    assign cpu_hold         = hold_q;
    assign intr_req         = req_q;
    assign intr_vec         = vec_q;
    assign arb_timeout      = tmo_q;

endmodule
